hold_led: RTL and testbench
===========================

// Module: hold_led
// PURPOSE
//   One-shot LED hold timer for the debit-PIN FSM indicator path. After reset is
//   released, LED is driven high for exactly CYCLE clock periods, then driven low.
//   LED stays low until the next reset. Each reset re-arms the timer.
//   Used to make a status LED visible for a fixed time, e.g. after PIN entry.
// PARAMETERS
//   CYCLE   10   hold length in clk cycles; legal range 1..2**16-1
//                CYCLE==0 triggers an elaboration-time $error
// PORTS
//   clk     in   1   system clock; all state updates on the rising edge
//   reset   in   1   asynchronous, active-low reset (0 = reset asserted)
//   LED     out  1   LED drive, registered, active-high
// BEHAVIOUR
//   Reset
//     - One clock; reset is asynchronous and active-low.
//     - While reset==0: state=ARM, cnt=0, LED=0, all applied immediately.
//     - Reset release is sampled synchronously: the first rising edge with
//       reset==1 is "edge 1".
//   States
//     - ARM : waiting for the first edge after reset.
//     - HOLD: LED high, counting.
//     - DONE: LED low, terminal.
//   Transitions (rising clk, reset==1)
//     - ARM  -> HOLD: LED<=1, cnt<=1.
//     - HOLD, cnt<CYCLE: cnt<=cnt+1, LED stays 1.
//     - HOLD, cnt==CYCLE: -> DONE, LED<=0, cnt holds.
//     - DONE -> DONE: LED=0, cnt frozen.
//   Timing
//     - LED rises 1 clk after reset release (at edge 1).
//     - LED falls at edge CYCLE+1.
//     - LED is high for exactly CYCLE full clk periods.
//   Widths
//     - cnt width is $clog2(CYCLE+1).
//     - cnt never exceeds CYCLE.
//     - No wrap-around: cnt never increments in DONE.
//   Boundaries
//     - CYCLE==1: LED high for exactly one period (edge 1 to edge 2).
//     - Reset asserted mid-HOLD: LED drops to 0 asynchronously.
//       On release the full CYCLE hold restarts from the ARM state.
//     - Reset asserted in DONE: re-arms; the next release gives a new full pulse.
//     - Reset pulses shorter than one clk period still clear the state
//       (asynchronous assert).
//     - Reset deasserted for exactly one edge, then reasserted:
//       LED is 1 for that single period only.
//   Encoding
//     - LED is a flop output, not decoded combinationally from state.
//     - Illegal state encodings recover to DONE, with LED=0.
// STRUCTURE
//   - Shared package: typedef enum logic [1:0] {ARM, HOLD, DONE} hold_state_t.
//     hold_state_t is shared with the PIN FSM.
//   - One sub-module: hold_counter, a CYCLE-bounded up-counter.
//     Inputs: clear, enable. Output: terminal flag (cnt==CYCLE).
//   - Top level: the FSM plus the LED flop.
// TESTING  (CYCLE=10, clk period 10 ns)
//   1. Reset low, then released before edge 1 -> LED=1 at edges 1..10,
//      LED=0 at edge 11, LED still 0 at edge 20.
//   2. Reset asserted at edge 5 of HOLD -> LED=0 immediately (asynchronous);
//      after release, LED=1 for 10 more cycles.
//   3. Reset asserted in DONE (edge 15), then released -> new 10-cycle pulse.
//   4. Random reset each cycle for 40 cycles -> LED==1 only if reset==1 for
//      1..10 consecutive edges since the last reset; a reference-model
//      scoreboard checks every edge.
//   5. CYCLE=1 build -> LED high for exactly one period.
//      CYCLE=0 build -> elaboration fails.
//   6. Reset glitch narrower than half a period, mid-HOLD -> LED clears and the
//      counter restarts from the ARM state.

Source files
------------

// File: rtl/hold_led_pkg.sv
// Shared types for the LED hold timer and the PIN FSM indicator path.
package hold_led_pkg;

    typedef enum logic [1:0] {
        ARM  = 2'b00,
        HOLD = 2'b01,
        DONE = 2'b10
    } hold_state_t;

    // Counter width for a hold of c cycles; kept at least 1 bit so a bad CYCLE still elaborates to its $error.
    function automatic int unsigned cnt_width(input int unsigned c);
        return (c < 1) ? 1 : $clog2(c + 1);
    endfunction

endpackage

// File: rtl/hold_led_counter.sv
// CYCLE-bounded up-counter; saturates at CYCLE and flags it on term_o.
module hold_counter
    import hold_led_pkg::*;
#(
    parameter int unsigned CYCLE = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic term_o
);

    localparam int unsigned W = cnt_width(CYCLE);
    localparam logic [W-1:0] CYCLE_W = W'(CYCLE);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (enable_i && (cnt_q < CYCLE_W))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign term_o = (cnt_q == CYCLE_W);

endmodule

// File: rtl/hold_led.sv
// One-shot LED hold timer: LED high for CYCLE clocks after reset release, then low until next reset.
module hold_led
    import hold_led_pkg::*;
#(
    parameter int unsigned CYCLE = 10
) (
    input  logic clk,
    input  logic reset,
    output logic LED
);

    if (CYCLE < 1 || CYCLE > 65535) begin : g_bad_cycle
        $error("hold_led: CYCLE=%0d outside legal range 1..65535", CYCLE);
    end

    hold_state_t state_q, state_d;
    logic        led_q, led_d;
    logic        cnt_clr, cnt_en, cnt_term;

    hold_counter #(.CYCLE(CYCLE)) u_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .clear_i  (cnt_clr),
        .enable_i (cnt_en),
        .term_o   (cnt_term)
    );

    always_comb begin
        state_d = state_q;
        led_d   = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ARM: begin
                state_d = HOLD;
                led_d   = 1'b1;
                cnt_en  = 1'b1;
            end
            HOLD: begin
                if (cnt_term) begin
                    state_d = DONE;
                end else begin
                    led_d  = 1'b1;
                    cnt_en = 1'b1;
                end
            end
            DONE: state_d = DONE;
            // Unused encoding: park in the terminal state with the LED off.
            default: begin
                state_d = DONE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARM;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
        end
    end

    assign LED = led_q;

endmodule

// File: tb/tb_hold_led.sv
// Directed and scoreboard checks of hold_led at CYCLE=10 and CYCLE=1.
module tb_hold_led;

    logic clk;
    logic reset;
    logic led10, led1;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic rst;
        logic e10;
        logic e1;
    } vec_t;

    vec_t vq[$];

    hold_led #(.CYCLE(10)) dut (
        .clk   (clk),
        .reset (reset),
        .LED   (led10)
    );

    hold_led #(.CYCLE(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .LED   (led1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive reset mid-cycle, then sample 1ns after the following rising edge.
    task automatic step(input logic v);
        @(negedge clk);
        reset = v;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e10, input logic e1, input int n);
        vec_t v;
        v.rst = r; v.e10 = e10; v.e1 = e1;
        for (int k = 0; k < n; k++) vq.push_back(v);
    endtask

    initial begin
        int run;
        logic v;

        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("reset_led10", led10, 1'b0);
        check("reset_led1", led1, 1'b0);

        // Basic pulse, long tail in DONE.
        add(0, 0, 0, 2);
        add(1, 1, 1, 1);
        add(1, 1, 0, 9);
        add(1, 0, 0, 10);
        // Re-arm from DONE.
        add(0, 0, 0, 1);
        add(1, 1, 1, 1);
        add(1, 1, 0, 9);
        add(1, 0, 0, 2);
        // Released for exactly one edge.
        add(0, 0, 0, 1);
        add(1, 1, 1, 1);
        add(0, 0, 0, 2);

        foreach (vq[i]) begin
            step(vq[i].rst);
            check($sformatf("vec%0d_led10", i), led10, vq[i].e10);
            check($sformatf("vec%0d_led1", i), led1, vq[i].e1);
        end

        // Asynchronous reset mid-HOLD, then a fresh full pulse.
        for (int k = 1; k <= 5; k++) begin
            step(1'b1);
            check($sformatf("midhold_pre%0d", k), led10, 1'b1);
        end
        #2 reset = 1'b0;
        #1;
        check("midhold_async_clear", led10, 1'b0);
        step(1'b0);
        check("midhold_held", led10, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            step(1'b1);
            check($sformatf("midhold_post%0d", k), led10, (k <= 10));
        end

        // Sub-period reset glitch mid-HOLD.
        step(1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1);
            check($sformatf("glitch_pre%0d", k), led10, 1'b1);
        end
        reset = 1'b0;
        #1;
        check("glitch_clear10", led10, 1'b0);
        check("glitch_clear1", led1, 1'b0);
        #1 reset = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step(1'b1);
            check($sformatf("glitch_post%0d", k), led10, (k <= 10));
            check($sformatf("glitch_post1_%0d", k), led1, (k == 1));
        end

        // Random reset activity against a run-length reference.
        step(1'b0);
        run = 0;
        for (int k = 0; k < 40; k++) begin
            v = ($urandom_range(0, 7) != 0);
            step(v);
            run = v ? run + 1 : 0;
            check($sformatf("rand%0d_led10", k), led10, (run >= 1 && run <= 10));
            check($sformatf("rand%0d_led1", k), led1, (run == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
